// File: rtl/layer_serializer.sv
// Collects one layer's parallel, possibly skewed neuron results and replays them
// as an nn-beat serial stream, with one pending sample buffered behind the stream.
module layer_serializer #(
   parameter int unsigned nn         = 10,
   parameter int unsigned data_width = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [nn-1:0]              in_valid,
   input  logic [nn*data_width-1:0]   in_data_flat,
   output logic                       out_valid,
   output logic [data_width-1:0]      out_data,
   output logic                       out_last,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned IW = (nn > 1) ? $clog2(nn) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(nn - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                            state_q, state_d;
   logic [IW-1:0]                     idx_q, idx_d;
   logic [nn-1:0]                     coll_mask_q, coll_mask_d;
   logic [nn-1:0][data_width-1:0]     coll_data_q, coll_data_d;
   logic [nn-1:0][data_width-1:0]     send_data_q, send_data_d;
   logic                              overrun_q, overrun_d;

   logic [nn-1:0][data_width-1:0]     in_data;
   logic [nn-1:0][data_width-1:0]     coll_img;
   logic [nn-1:0]                     accept;
   logic                              coll_full;
   logic                              last_beat;
   logic                              transfer;

   assign in_data = in_data_flat;

   // State, buffers and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         coll_mask_q <= '0;
         coll_data_q <= '0;
         send_data_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         coll_mask_q <= coll_mask_d;
         coll_data_q <= coll_data_d;
         send_data_q <= send_data_d;
         overrun_q   <= overrun_d;
      end
   end

   // Collect image includes this cycle's first-time arrivals; repeats only flag overrun.
   always_comb begin
      accept = in_valid & ~coll_mask_q;
      for (int i = 0; i < int'(nn); i++) begin
         coll_img[i] = accept[i] ? in_data[i] : coll_data_q[i];
      end
      coll_full = &(coll_mask_q | accept);
      last_beat = (state_q == SEND) && (idx_q == LAST_IDX);
      transfer  = coll_full && ((state_q == IDLE) || last_beat);

      state_d     = state_q;
      idx_d       = idx_q;
      send_data_d = send_data_q;
      coll_data_d = coll_img;
      coll_mask_d = coll_mask_q | accept;
      overrun_d   = overrun_q | (|(in_valid & coll_mask_q));

      case (state_q)
         IDLE: ;
         SEND: begin
            if (last_beat) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A transfer reloads the send buffer and restarts the stream without a bubble.
      if (transfer) begin
         send_data_d = coll_img;
         coll_mask_d = '0;
         idx_d       = '0;
         state_d     = SEND;
      end
   end

   assign out_valid = (state_q == SEND);
   assign out_last  = last_beat;
   assign out_data  = out_valid ? send_data_q[idx_q] : '0;
   assign busy      = out_valid | (|coll_mask_q);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: stimulus pushes expected beats, a
// negedge monitor pops and compares every presented beat.
module tb_layer_serializer;

   localparam int unsigned NN = 10;
   localparam int unsigned DW = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic                clk;
   logic                rst;
   logic [NN-1:0]       in_valid;
   logic [NN*DW-1:0]    in_data_flat;
   logic                out_valid;
   logic [DW-1:0]       out_data;
   logic                out_last;
   logic                busy;
   logic                overrun;

   beat_t exp_q[$];
   int    n_vec;
   int    n_err;
   logic  mid;

   layer_serializer #(.nn(NN), .data_width(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data_flat (in_data_flat),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NN*DW-1:0] mk(input logic [DW-1:0] base, input logic [DW-1:0] step);
      logic [NN*DW-1:0] d;
      for (int i = 0; i < int'(NN); i++) d[i*DW +: DW] = base + DW'(i) * step;
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_sample(input logic [NN*DW-1:0] d);
      beat_t b;
      for (int i = 0; i < int'(NN); i++) begin
         b.data = d[i*DW +: DW];
         b.last = (i == int'(NN) - 1);
         exp_q.push_back(b);
      end
   endtask

   // Called at posedge+1; holds the strobe for exactly one sampling edge.
   task automatic strobe(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
      in_valid     = v;
      in_data_flat = d;
      @(posedge clk); #1;
      in_valid = '0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_q.size() == 0) done = 1'b1;
      end
      chk({name, "_drain"}, 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   // Monitor: in-order beat compare, gap detection inside a sample, idle outputs zero.
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         mid = 1'b0;
      end else if (out_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat at %0t",
                     out_data, out_last, $time);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
               n_err++;
               $display("FAIL beat: got data %0h last %0b, expected data %0h last %0b at %0t",
                        out_data, out_last, e.data, e.last, $time);
            end
         end
         mid = !out_last;
      end else begin
         if (mid) begin
            n_vec++;
            n_err++;
            $display("FAIL gap: got out_valid 0, expected 1 inside a sample at %0t", $time);
         end
         mid = 1'b0;
         n_vec++;
         if (out_data !== '0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL idle_out: got data %0h last %0b, expected 0 0 at %0t",
                     out_data, out_last, $time);
         end
      end
   end

   initial begin
      logic [NN*DW-1:0] d_a, d_b, d_dead;
      n_vec        = 0;
      n_err        = 0;
      mid          = 1'b0;
      rst          = 1'b1;
      in_valid     = '0;
      in_data_flat = '0;
      tick(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_overrun",   32'(overrun),   32'd0);
      rst = 1'b0;
      tick(2);

      // Aligned valids, 1-cycle latency.
      d_a = mk(16'd1, 16'd1);
      push_sample(d_a);
      strobe('1, d_a);
      chk("t1_latency", 32'(out_valid), 32'd1);
      wait_idle("t1");
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_overrun", 32'(overrun), 32'd0);

      // Skewed valids: lower half at cycle 0, upper half at cycle 3.
      d_a = mk(16'd0, 16'h0101);
      push_sample(d_a);
      strobe(10'h01F, d_a);
      chk("t2_busy_c1", 32'(busy), 32'd1);
      chk("t2_no_out_c1", 32'(out_valid), 32'd0);
      tick(2);
      chk("t2_no_out_c3", 32'(out_valid), 32'd0);
      strobe(10'h3E0, d_a);
      chk("t2_start_c4", 32'(out_valid), 32'd1);
      wait_idle("t2");

      // Back-to-back: B completes on A's 10th beat.
      d_a = mk(16'h1000, 16'd1);
      d_b = mk(16'h2000, 16'd1);
      push_sample(d_a);
      push_sample(d_b);
      strobe('1, d_a);
      tick(9);
      chk("t3_beat10_last", 32'(out_last), 32'd1);
      strobe('1, d_b);
      chk("t3_b_start", 32'(out_valid), 32'd1);
      wait_idle("t3");
      chk("t3_overrun", 32'(overrun), 32'd0);

      // Overrun on a pending slot: neuron 3 strobes DEAD while B waits.
      d_a = mk(16'h3000, 16'd3);
      d_b = mk(16'h4000, 16'd5);
      d_dead = d_b;
      d_dead[3*DW +: DW] = 16'hDEAD;
      push_sample(d_a);
      push_sample(d_b);
      strobe('1, d_a);
      tick(2);
      strobe('1, d_b);
      chk("t4_no_overrun_yet", 32'(overrun), 32'd0);
      strobe(10'h008, d_dead);
      chk("t4_overrun_set", 32'(overrun), 32'd1);
      wait_idle("t4");
      chk("t4_overrun_sticky", 32'(overrun), 32'd1);

      // Overrun clear by reset, clean sample keeps it low.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_overrun_clr", 32'(overrun), 32'd0);
      tick(1);
      d_a = mk(16'h5000, 16'd7);
      push_sample(d_a);
      strobe('1, d_a);
      wait_idle("t6");
      chk("t6_overrun_clean", 32'(overrun), 32'd0);

      // Asynchronous reset during beat 5, then a fresh sample.
      d_a = mk(16'h6000, 16'd1);
      push_sample(d_a);
      strobe('1, d_a);
      tick(4);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_data",  32'(out_data),  32'd0);
      chk("t5_rst_last",  32'(out_last),  32'd0);
      chk("t5_rst_busy",  32'(busy),      32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      tick(1);
      d_a = mk(16'h7000, 16'd2);
      push_sample(d_a);
      strobe('1, d_a);
      chk("t5_fresh_start", 32'(out_data), 32'h7000);
      wait_idle("t5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Sequencing controller between two fully connected layers. It collects the per-neuron results of one layer, which arrive in parallel and possibly skewed. It then replays them one value per cycle as the serial input stream of the next layer (`myinput`/`myinputvalid` style). A single pending buffer lets one sample be collected while the previous one is still being streamed out.

## Interface
- `nn`, default 10: neurons in the upstream layer, equal to the beats per output sample; must be ≥ 2.
- `data_width`, default 16: width of each neuron result.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  nn: per-neuron result strobe from the upstream layer (bit i ↔ neuron i).
- `in_data_flat`  in  nn*data_width: neuron i result at bits `[i*data_width +: data_width]`.
- `out_valid`  out  1: serial beat valid, drives the downstream layer input valid.
- `out_data`  out  data_width: serial beat value.
- `out_last`  out  1: high on the final beat (index nn-1) of a sample.
- `busy`  out  1: high while streaming or while a collected sample is pending.
- `overrun`  out  1: sticky error flag, cleared only by `rst`.

## Operation
- **Collect buffer:** `coll_data[nn]` plus `coll_mask[nn]`.
  - On `in_valid[i]` with `coll_mask[i]==0`: store that neuron's slice and set `coll_mask[i]`.
  - On `in_valid[i]` with `coll_mask[i]==1`: data is dropped, the first value is kept, and `overrun` is set.
- **Collect full:** `coll_full = &(coll_mask | accepted_this_cycle)`. This counts bits that arrive in the completing cycle.
- **Send buffer:** `send_data[nn]`, an index counter `idx` (width `$clog2(nn)`), and a state register.
- **State IDLE:**
  - `out_valid=0`.
  - If `coll_full`: copy the full collect image (including this cycle's arrivals) into `send_data`, clear `coll_mask`, set `idx=0`, go to SEND.
- **State SEND:**
  - `out_valid=1`, `out_data=send_data[idx]`, `out_last=(idx==nn-1)`.
  - `idx` increments each cycle.
  - At `idx==nn-1`:
    - If `coll_full`: transfer again, `idx=0`, stay in SEND. This gives back-to-back streaming with no bubble.
    - Otherwise go to IDLE.
- **While SEND is not on its last beat:** a full collect buffer holds its contents and mask.
  - Further `in_valid` bits are already set, so they raise `overrun`.
  - Bits still clear in a partially filled buffer accumulate normally.
- **Same-cycle transfer and new arrivals:** when a transfer happens, `in_valid` bits asserted in that cycle belong to the sample being transferred. `coll_mask` clears to all zeros.
- **`busy`:** `(state==SEND) | (|coll_mask)`.
- **Downstream acceptance:** no backpressure; the downstream layer accepts every beat.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `overrun=0`, `coll_mask=0`, `idx=0`, state IDLE.
- **Reset mid-operation:** all of the above take effect immediately and asynchronously. Any partially streamed sample is discarded with no further beats.
- **Latency:** the completing `in_valid` is sampled at edge T; the first `out_valid` beat is in the cycle after edge T (1-cycle latency).
- **Sample length:** exactly nn consecutive `out_valid` cycles, with no gaps inside a sample.
- **Throughput:** one sample per nn cycles sustained, provided each new sample completes no later than the last beat of the previous one.
- **Output registering:** `out_data` is a mux of registered `send_data` by registered `idx`, so it is glitch-free relative to `clk`. `out_valid` and `out_last` are decoded from registered state and `idx` only.
- **Outputs during IDLE:** `out_data` is 0 and `out_last` is 0.
- **`overrun`:** asserts in the cycle after the offending `in_valid` edge and stays high until `rst`.

## Test plan
1. **Aligned valids:** `in_valid=10'h3FF` for one cycle with neuron i = i+1. Required: 1 cycle later, 10 consecutive beats 1,2,…,10; `out_last` only on value 10; then `out_valid=0`; `busy` falls after the last beat; `overrun=0`.
2. **Skewed valids:** neurons 0–4 strobe at cycle 0, neurons 5–9 at cycle 3, data i*16'h0101. Required: no output before cycle 4; then 10 beats in neuron order; `busy=1` from cycle 1.
3. **Back-to-back:** sample A streaming, and sample B completes on A's 10th beat. Required: 20 consecutive `out_valid` cycles, A then B; `out_last` on beats 10 and 20; no overrun.
4. **Overrun on a pending slot:**
   - Setup: sample A streaming; sample B fully collected at A's beat 3; neuron 3 strobes again with 16'hDEAD before A finishes.
   - Required: `overrun=1` sticky; B streams with its original neuron-3 value, not 16'hDEAD.
5. **Reset mid-send:** assert `rst` asynchronously during beat 5 of a sample. Required: `out_valid`, `out_data`, `out_last`, `busy` = 0 immediately. After release, a fresh aligned sample streams correctly starting from neuron 0.
6. **Overrun clear:** after test 4, pulse `rst`. Required: `overrun=0`; a clean sample leaves it 0.
